// File: rtl/card_deal_pkg.sv
// rtl/card_deal_pkg.sv - shared state encoding, hand ids and defaults for the card deal controller
package card_deal_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    typedef enum logic {
        PLAYER = 1'b0,
        DEALER = 1'b1
    } hand_e;

    // bit i is the hand receiving opening-deal slot i: player, dealer, player, dealer
    localparam logic [3:0] DEAL_ORDER = 4'b1010;

    localparam int unsigned DECK_SIZE_DEF = 52;
    localparam int unsigned CARD_LAT_DEF  = 2;

endpackage

// File: rtl/card_deal_ctrl_if.sv
// rtl/card_deal_ctrl_if.sv - game/datapath side signals of card_deal_ctrl; card_err_o exists only with CARD_CHECK_EN
interface card_deal_ctrl_if;

    logic       start_deal_i;
    logic       p_req_i;
    logic       d_req_i;
    logic [7:0] card_i;
    logic       req_card_o;
    logic [7:0] card_o;
    logic       p_valid_o;
    logic       d_valid_o;
    logic       busy_o;
    logic       deck_empty_o;
    logic [5:0] dealt_cnt_o;
`ifdef CARD_CHECK_EN
    logic       card_err_o;
`endif

    modport slave (
        input  start_deal_i, p_req_i, d_req_i, card_i,
        output req_card_o, card_o, p_valid_o, d_valid_o, busy_o, deck_empty_o, dealt_cnt_o
`ifdef CARD_CHECK_EN
        , output card_err_o
`endif
    );

    modport master (
        output start_deal_i, p_req_i, d_req_i, card_i,
        input  req_card_o, card_o, p_valid_o, d_valid_o, busy_o, deck_empty_o, dealt_cnt_o
`ifdef CARD_CHECK_EN
        , input card_err_o
`endif
    );

endinterface

// File: rtl/card_deal_rr_arb.sv
// rtl/card_deal_rr_arb.sv - two-requester round-robin arbiter for player/dealer hits
module card_deal_rr_arb
    import card_deal_pkg::*;
(
    input  logic       clk_ctrl_i,
    input  logic       rst_ctrl_i,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    // last_q holds the most recently granted hand; it resets to PLAYER so a first tie goes to the dealer
    hand_e last_q;

    always_comb begin
        grant = 2'b00;
        if (req[PLAYER] && (!req[DEALER] || (last_q == DEALER))) begin
            grant[PLAYER] = 1'b1;
        end else if (req[DEALER]) begin
            grant[DEALER] = 1'b1;
        end
    end

    always_ff @(posedge clk_ctrl_i or posedge rst_ctrl_i) begin
        if (rst_ctrl_i) begin
            last_q <= PLAYER;
        end else if (adv && (grant != 2'b00)) begin
            last_q <= grant[DEALER] ? DEALER : PLAYER;
        end
    end

endmodule

// File: rtl/card_deal_ctrl.sv
// rtl/card_deal_ctrl.sv - opening deal and hit sequencer for the deck datapath; CARD_CHECK_EN adds card validation
module card_deal_ctrl
    import card_deal_pkg::*;
#(
    parameter int unsigned CARD_LAT  = CARD_LAT_DEF,
    parameter int unsigned DECK_SIZE = DECK_SIZE_DEF
) (
    input  logic            clk_ctrl_i,
    input  logic            rst_ctrl_i,
    card_deal_ctrl_if.slave bus
);

    localparam logic [2:0] LAT_LAST = 3'(CARD_LAT - 1);
    localparam logic [5:0] DECK_MAX = 6'(DECK_SIZE);

    logic [1:0] state_q, state_d;
    logic [2:0] lat_q;
    logic [1:0] slot_q;
    logic       deal_q;
    hand_e      hand_q;
    logic       err_q;
    logic       req_q;
    logic       p_vld_q;
    logic       d_vld_q;
    logic       busy_q;
    logic       empty_q;
    logic [7:0] card_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_inc;
    logic [1:0] grant;
    logic       accept_deal;
    logic       accept_hit;
    logic       card_bad;
    logic       lat_done;

    assign cnt_inc  = cnt_q + 6'd1;
    assign lat_done = (lat_q == LAT_LAST);

`ifdef CARD_CHECK_EN
    assign card_bad = (bus.card_i == 8'd0) || (bus.card_i > 8'(DECK_SIZE));
    assign bus.card_err_o = err_q;
`else
    assign card_bad = 1'b0;
`endif

    card_deal_rr_arb u_arb (
        .clk_ctrl_i (clk_ctrl_i),
        .rst_ctrl_i (rst_ctrl_i),
        .req        ({bus.d_req_i, bus.p_req_i}),
        .adv        (accept_hit),
        .grant      (grant)
    );

    always_comb begin
        state_d     = state_q;
        accept_deal = 1'b0;
        accept_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    if (bus.start_deal_i) begin
                        accept_deal = 1'b1;
                        state_d     = ST_REQ;
                    end else if (grant != 2'b00) begin
                        accept_hit = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (lat_done) state_d = ST_DELIVER;
            default: begin
                // a rejected card retries the same slot; a deal stops early if the deck runs out
                if (err_q || (deal_q && (slot_q != 2'd3) && (cnt_inc < DECK_MAX))) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_ctrl_i or posedge rst_ctrl_i) begin
        if (rst_ctrl_i) begin
            state_q <= ST_IDLE;
            lat_q   <= 3'd0;
            slot_q  <= 2'd0;
            deal_q  <= 1'b0;
            hand_q  <= PLAYER;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            p_vld_q <= 1'b0;
            d_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            empty_q <= 1'b0;
            card_q  <= 8'd0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            req_q   <= (state_d == ST_REQ);
            p_vld_q <= 1'b0;
            d_vld_q <= 1'b0;
            err_q   <= 1'b0;
            if (accept_deal) begin
                deal_q <= 1'b1;
                slot_q <= 2'd0;
                hand_q <= hand_e'(DEAL_ORDER[0]);
            end
            if (accept_hit) begin
                deal_q <= 1'b0;
                hand_q <= grant[DEALER] ? DEALER : PLAYER;
            end
            if (state_q == ST_REQ) begin
                lat_q <= 3'd0;
            end
            if (state_q == ST_WAIT) begin
                lat_q <= lat_q + 3'd1;
                if (lat_done) begin
                    err_q <= card_bad;
                    if (!card_bad) begin
                        card_q  <= bus.card_i;
                        p_vld_q <= (hand_q == PLAYER);
                        d_vld_q <= (hand_q == DEALER);
                    end
                end
            end
            if ((state_q == ST_DELIVER) && !err_q) begin
                if (cnt_q != DECK_MAX) begin
                    cnt_q <= cnt_inc;
                end
                empty_q <= (cnt_inc >= DECK_MAX);
                if (deal_q) begin
                    slot_q <= slot_q + 2'd1;
                    hand_q <= hand_e'(DEAL_ORDER[slot_q + 2'd1]);
                end
                if (state_d == ST_IDLE) begin
                    deal_q <= 1'b0;
                end
            end
        end
    end

    assign bus.req_card_o   = req_q;
    assign bus.card_o       = card_q;
    assign bus.p_valid_o    = p_vld_q;
    assign bus.d_valid_o    = d_vld_q;
    assign bus.busy_o       = busy_q;
    assign bus.deck_empty_o = empty_q;
    assign bus.dealt_cnt_o  = cnt_q;

endmodule

// File: tb/tb_card_deal_ctrl.sv
// tb/tb_card_deal_ctrl.sv - scoreboard bench for card_deal_ctrl with a latency-accurate deck model
module tb_card_deal_ctrl;

    localparam int         LAT  = 2;
    localparam int         DECK = 52;
    localparam logic [7:0] JUNK = 8'hEE;
    localparam logic [1:0] K_P   = 2'd0;
    localparam logic [1:0] K_D   = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] card;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    card_deal_ctrl_if bus ();

    card_deal_ctrl #(
        .CARD_LAT  (LAT),
        .DECK_SIZE (DECK)
    ) dut (
        .clk_ctrl_i (clk),
        .rst_ctrl_i (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_req    = 0;
    int         n_deliv  = 0;
    int         n_err    = 0;
    int         cd       = 0;
    exp_t       sb[$];
    logic [1:0] hand_exp[$];
    logic [7:0] card_src[$];
    int         dcyc[$];
    logic [7:0] drv_card;
    logic [1:0] mon_kind;
    exp_t       mon_e;
    logic       err_s;

`ifdef CARD_CHECK_EN
    assign err_s = bus.card_err_o;
`else
    assign err_s = 1'b0;
`endif

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic card_is_bad(input logic [7:0] c);
`ifdef CARD_CHECK_EN
        return (c == 8'd0) || (c > 8'(DECK));
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // deck model: card_i carries the card only in cycle req+LAT, junk otherwise
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cd = 0;
            sb.delete();
            bus.card_i = JUNK;
        end else begin
            bus.card_i = JUNK;
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    if (card_src.size() != 0) drv_card = card_src.pop_front();
                    else drv_card = 8'($urandom_range(1, DECK));
                    bus.card_i = drv_card;
                    if (card_is_bad(drv_card)) begin
                        sb.push_back('{K_ERR, drv_card, cyc});
                    end else begin
                        check_eq("unexp_req", int'(hand_exp.size() != 0), 1);
                        if (hand_exp.size() != 0) sb.push_back('{hand_exp.pop_front(), drv_card, cyc});
                    end
                end
            end
            if (bus.req_card_o) cd = LAT;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_card_o) n_req++;
            if (bus.p_valid_o || bus.d_valid_o || err_s) begin
                mon_kind = err_s ? K_ERR : (bus.d_valid_o ? K_D : K_P);
                check_eq("one_hot_out", int'(bus.p_valid_o) + int'(bus.d_valid_o) + int'(err_s), 1);
                if (err_s) n_err++;
                else begin
                    n_deliv++;
                    dcyc.push_back(cyc);
                end
                check_eq("unexp_valid", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_eq("kind", int'(mon_kind), int'(mon_e.kind));
                    if (!err_s) check_eq("card", int'(bus.card_o), int'(mon_e.card));
                    check_eq("deliver_cycle", cyc, mon_e.cyc + 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #7;
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int k = 0;
        while ((n_deliv < target) && (k < budget)) begin
            tick();
            k++;
        end
        check_eq("deliv_count", n_deliv, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   int'(bus.req_card_o),   0);
        check_eq({tag, "_card"},  int'(bus.card_o),       0);
        check_eq({tag, "_pv"},    int'(bus.p_valid_o),    0);
        check_eq({tag, "_dv"},    int'(bus.d_valid_o),    0);
        check_eq({tag, "_busy"},  int'(bus.busy_o),       0);
        check_eq({tag, "_empty"}, int'(bus.deck_empty_o), 0);
        check_eq({tag, "_cnt"},   int'(bus.dealt_cnt_o),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int a;
        int k;
        int model_cnt;
        int rem;
        int req_snap;

        bus.start_deal_i = 1'b0;
        bus.p_req_i      = 1'b0;
        bus.d_req_i      = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // opening deal with a second start pulse while busy
        card_src = '{8'd5, 8'd17, 8'd30, 8'd44};
        hand_exp = '{K_P, K_D, K_P, K_D};
        base = n_deliv;
        d0   = dcyc.size();
        a    = cyc;
        bus.start_deal_i = 1'b1;
        tick();
        bus.start_deal_i = 1'b0;
        repeat (5) tick();
        bus.start_deal_i = 1'b1;
        tick();
        bus.start_deal_i = 1'b0;
        wait_deliv(base + 4, 40);
        if (dcyc.size() >= d0 + 4) begin
            check_eq("deal_first_cycle", dcyc[d0], a + LAT + 2);
            for (int i = 1; i < 4; i++) check_eq("deal_spacing", dcyc[d0 + i] - dcyc[d0 + i - 1], LAT + 2);
        end
        repeat (10) tick();
        check_eq("deal_no_requeue", n_deliv, base + 4);
        check_eq("deal_cnt", int'(bus.dealt_cnt_o), 4);
        check_eq("deal_busy_low", int'(bus.busy_o), 0);

        // both hands requesting: dealer wins first tie, then alternate
        hand_exp = '{K_D, K_P, K_D, K_P};
        base = n_deliv;
        bus.p_req_i = 1'b1;
        bus.d_req_i = 1'b1;
        wait_deliv(base + 4, 60);
        bus.p_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        tick();
        check_eq("rr_cnt", int'(bus.dealt_cnt_o), 8);

        // start and player hit together: deal first, then the hit
        hand_exp = '{K_P, K_D, K_P, K_D, K_P};
        base = n_deliv;
        bus.p_req_i      = 1'b1;
        bus.start_deal_i = 1'b1;
        tick();
        bus.start_deal_i = 1'b0;
        wait_deliv(base + 5, 60);
        bus.p_req_i = 1'b0;
        tick();
        check_eq("start_hit_cnt", int'(bus.dealt_cnt_o), 13);

        // reset during WAIT
        bus.p_req_i = 1'b1;
        k = 0;
        while (!bus.req_card_o && (k < 20)) begin
            tick();
            k++;
        end
        check_eq("rst_req_seen", int'(bus.req_card_o), 1);
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        bus.p_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        hand_exp.delete();
        card_src.delete();
        base = n_deliv;
        repeat (10) tick();
        check_eq("rst_no_valid", n_deliv, base);
        model_cnt = 0;

`ifdef CARD_CHECK_EN
        // invalid card retried, then delivered
        card_src = '{8'd0, 8'd9};
        hand_exp = '{K_P};
        base = n_deliv;
        bus.p_req_i = 1'b1;
        wait_deliv(base + 1, 40);
        bus.p_req_i = 1'b0;
        check_eq("err_pulses", n_err, 1);
        tick();
        check_eq("err_cnt", int'(bus.dealt_cnt_o), 1);
        model_cnt = 1;
`endif

        // deck exhaustion with a continuous player request
        rem = DECK - model_cnt;
        for (int i = 0; i < rem; i++) hand_exp.push_back(K_P);
        base = n_deliv;
        bus.p_req_i = 1'b1;
        wait_deliv(base + rem, rem * 8 + 50);
        check_eq("empty_not_yet", int'(bus.deck_empty_o), 0);
        tick();
        check_eq("empty_set", int'(bus.deck_empty_o), 1);
        check_eq("empty_cnt", int'(bus.dealt_cnt_o), DECK);
        req_snap = n_req;
        repeat (20) tick();
        check_eq("empty_no_req", n_req, req_snap);
        bus.start_deal_i = 1'b1;
        tick();
        bus.start_deal_i = 1'b0;
        repeat (20) tick();
        check_eq("empty_deal_req", n_req, req_snap);
        check_eq("empty_deal_deliv", n_deliv, base + rem);
        check_eq("empty_busy", int'(bus.busy_o), 0);
        bus.p_req_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
